// File: rtl/hdmi_acr_pkg.sv
// Shared constants for the HDMI audio clock regeneration generator.
package hdmi_acr_pkg;

    localparam int ACR_N_WIDTH = 20;
    localparam int ACR_SPA_WIDTH = ACR_N_WIDTH - 7;

    localparam logic [1:0] ACR_RATE_32K  = 2'b00;
    localparam logic [1:0] ACR_RATE_44K1 = 2'b01;
    localparam logic [1:0] ACR_RATE_48K  = 2'b10;

    // Samples per ACR period: N/128.
    function automatic logic [ACR_SPA_WIDTH-1:0] acr_spa(
        input logic [ACR_N_WIDTH-1:0] n
    );
        return n[ACR_N_WIDTH-1:7];
    endfunction

endpackage

// File: rtl/hdmi_acr_gen_cts_meter.sv
// Saturating clk counter between ACR events; the first period after a
// restart only arms the meter. Used when HDMI_ACR_CTS_MEASURE_EN is defined.
module acr_cts_meter #(
    parameter int CTS_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 acr_evt,
    output logic                 meas_valid,
    output logic [CTS_WIDTH-1:0] meas_cts
);

    localparam logic [CTS_WIDTH-1:0] CNT_MAX = '1;

    logic [CTS_WIDTH-1:0] cnt_q;
    logic                 armed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (restart) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (acr_evt) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A saturated period is not a usable measurement.
    assign meas_valid = armed_q && (cnt_q != CNT_MAX);
    assign meas_cts   = cnt_q + 1'b1;

endmodule

// File: rtl/hdmi_acr_gen.sv
// HDMI ACR packet strobe and N/CTS generator for 32k/44.1k/48k families.
// Define HDMI_ACR_CTS_MEASURE_EN to report measured CTS instead of nominal.
module hdmi_acr_gen
    import hdmi_acr_pkg::*;
#(
    parameter int N_32K     = 4096,
    parameter int N_44K1    = 6272,
    parameter int N_48K     = 6144,
    parameter int CTS_32K   = 27000,
    parameter int CTS_44K1  = 30000,
    parameter int CTS_48K   = 27000,
    parameter int CTS_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             rate_sel,
    input  logic                   sample_stb,
    output logic                   acr_stb,
    output logic [ACR_N_WIDTH-1:0] acr_n,
    output logic [CTS_WIDTH-1:0]   acr_cts,
    output logic                   cts_measured
);

    localparam logic [ACR_N_WIDTH-1:0] N32  = ACR_N_WIDTH'(N_32K);
    localparam logic [ACR_N_WIDTH-1:0] N441 = ACR_N_WIDTH'(N_44K1);
    localparam logic [ACR_N_WIDTH-1:0] N48  = ACR_N_WIDTH'(N_48K);
    localparam logic [CTS_WIDTH-1:0]   C32  = CTS_WIDTH'(CTS_32K);
    localparam logic [CTS_WIDTH-1:0]   C441 = CTS_WIDTH'(CTS_44K1);
    localparam logic [CTS_WIDTH-1:0]   C48  = CTS_WIDTH'(CTS_48K);

    logic [1:0]               rate_q;
    logic                     rate_chg;
    logic                     rate_chg_q;
    logic                     restart;
    logic                     acr_evt;
    logic [ACR_SPA_WIDTH-1:0] cnt_q;
    logic [ACR_SPA_WIDTH-1:0] spa;
    logic [ACR_N_WIDTH-1:0]   n_nom;
    logic [CTS_WIDTH-1:0]     cts_nom;

    always_comb begin
        n_nom   = N48;
        cts_nom = C48;
        case (rate_q)
            ACR_RATE_32K: begin
                n_nom   = N32;
                cts_nom = C32;
            end
            ACR_RATE_44K1: begin
                n_nom   = N441;
                cts_nom = C441;
            end
            default: begin
                n_nom   = N48;
                cts_nom = C48;
            end
        endcase
    end

    assign spa      = acr_spa(n_nom);
    assign rate_chg = (rate_sel != rate_q);
    // A rate change or disable wins over a coincident sample.
    assign restart  = rate_chg || !enable;
    assign acr_evt  = sample_stb && !restart && (cnt_q == spa - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q     <= ACR_RATE_48K;
            rate_chg_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rate_q     <= rate_sel;
            rate_chg_q <= rate_chg;
            if (restart || acr_evt) begin
                cnt_q <= '0;
            end else if (sample_stb) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef HDMI_ACR_CTS_MEASURE_EN
    logic                 meas_valid;
    logic [CTS_WIDTH-1:0] meas_cts;

    acr_cts_meter #(
        .CTS_WIDTH (CTS_WIDTH)
    ) u_meter (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .acr_evt    (acr_evt),
        .meas_valid (meas_valid),
        .meas_cts   (meas_cts)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acr_stb      <= 1'b0;
            acr_n        <= N48;
            acr_cts      <= C48;
            cts_measured <= 1'b0;
        end else begin
            acr_stb <= acr_evt;
            if (rate_chg_q) begin
                acr_n        <= n_nom;
                acr_cts      <= cts_nom;
                cts_measured <= 1'b0;
            end else if (acr_evt) begin
                acr_n <= n_nom;
                if (meas_valid) begin
                    acr_cts      <= meas_cts;
                    cts_measured <= 1'b1;
                end else begin
                    acr_cts      <= cts_nom;
                    cts_measured <= 1'b0;
                end
            end else if (!enable) begin
                cts_measured <= 1'b0;
            end
        end
    end
`else
    assign cts_measured = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acr_stb <= 1'b0;
            acr_n   <= N48;
            acr_cts <= C48;
        end else begin
            acr_stb <= acr_evt;
            if (rate_chg_q || acr_evt) begin
                acr_n   <= n_nom;
                acr_cts <= cts_nom;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_acr_gen.sv
// Directed bench for hdmi_acr_gen; measured-CTS checks follow the build macro.
module tb_hdmi_acr_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  rate_sel;
    logic        sample_stb;
    logic        acr_stb;
    logic [19:0] acr_n;
    logic [19:0] acr_cts;
    logic        cts_measured;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int base;

    hdmi_acr_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rate_sel     (rate_sel),
        .sample_stb   (sample_stb),
        .acr_stb      (acr_stb),
        .acr_n        (acr_n),
        .acr_cts      (acr_cts),
        .cts_measured (cts_measured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (acr_stb === 1'b1) stb_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic send(input int k, input int gap);
        for (int i = 0; i < k; i++) begin
            pulse1();
            repeat (gap - 1) tick();
        end
    endtask

    localparam int MEAS_CTS = 24000;
    int exp_cts2;
    int exp_meas2;

    initial begin
`ifdef HDMI_ACR_CTS_MEASURE_EN
        exp_cts2  = MEAS_CTS;
        exp_meas2 = 1;
`else
        exp_cts2  = 27000;
        exp_meas2 = 0;
`endif
        reset      = 1'b1;
        enable     = 1'b0;
        rate_sel   = 2'b10;
        sample_stb = 1'b0;
        repeat (3) tick();
        chk("rst_stb", acr_stb, 0);
        chk("rst_n", acr_n, 6144);
        chk("rst_cts", acr_cts, 27000);
        chk("rst_meas", cts_measured, 0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // 48k: one strobe after 48 samples
        base = stb_cnt;
        send(47, 10);
        chk("t1_early", stb_cnt - base, 0);
        pulse1();
        chk("t1_stb", acr_stb, 1);
        chk("t1_n", acr_n, 6144);
        chk("t1_cts", acr_cts, 27000);
        tick();
        chk("t1_stb_1cyc", acr_stb, 0);
        repeat (8) tick();

        // 44.1k: reload two cycles after change, strobes at 49/98
        rate_sel = 2'b01;
        tick();
        chk("t2_n_c1", acr_n, 6144);
        tick();
        chk("t2_n_c2", acr_n, 6272);
        chk("t2_cts", acr_cts, 30000);
        base = stb_cnt;
        send(48, 10);
        chk("t2_early", stb_cnt - base, 0);
        pulse1();
        chk("t2_stb49", acr_stb, 1);
        repeat (9) tick();
        send(48, 10);
        pulse1();
        chk("t2_stb98", acr_stb, 1);
        tick();
        chk("t2_count", stb_cnt - base, 2);
        repeat (8) tick();

        // 48k -> 11 is a change and restarts the period
        rate_sel = 2'b10;
        repeat (2) tick();
        send(20, 10);
        rate_sel = 2'b11;
        repeat (2) tick();
        chk("t3_n_11", acr_n, 6144);
        base = stb_cnt;
        send(47, 10);
        chk("t3_early_11", stb_cnt - base, 0);
        pulse1();
        chk("t3_stb_11", acr_stb, 1);
        repeat (9) tick();

        // partial 48k period then 32k: needs 32 fresh samples
        send(20, 10);
        rate_sel = 2'b00;
        repeat (2) tick();
        chk("t3_n_32k", acr_n, 4096);
        chk("t3_cts_32k", acr_cts, 27000);
        base = stb_cnt;
        send(31, 10);
        chk("t3_early_32k", stb_cnt - base, 0);
        pulse1();
        chk("t3_stb_32k", acr_stb, 1);
        repeat (9) tick();

        // disable with a completing sample coincident
        rate_sel = 2'b10;
        repeat (2) tick();
        send(47, 10);
        enable     = 1'b0;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        chk("t4_coinc", acr_stb, 0);
        tick();
        chk("t4_meas", cts_measured, 0);
        base = stb_cnt;
        send(59, 10);
        chk("t4_off", stb_cnt - base, 0);
        chk("t4_n_hold", acr_n, 6144);
        enable = 1'b1;
        tick();
        send(47, 10);
        chk("t4_reen_early", stb_cnt - base, 0);
        pulse1();
        chk("t4_reen_stb", acr_stb, 1);
        repeat (9) tick();

        // CTS measurement with 500-cycle sample spacing
        rate_sel = 2'b11;
        repeat (2) tick();
        send(47, 500);
        pulse1();
        chk("t5_stb1", acr_stb, 1);
        chk("t5_cts1", acr_cts, 27000);
        chk("t5_meas1", cts_measured, 0);
        repeat (499) tick();
        send(47, 500);
        pulse1();
        chk("t5_stb2", acr_stb, 1);
        chk("t5_cts2", acr_cts, exp_cts2);
        chk("t5_meas2", cts_measured, exp_meas2);
        repeat (9) tick();

        // asynchronous reset mid-period
        send(30, 10);
        reset = 1'b1;
        #2;
        chk("t6_stb", acr_stb, 0);
        chk("t6_n", acr_n, 6144);
        chk("t6_cts", acr_cts, 27000);
        chk("t6_meas", cts_measured, 0);
        rate_sel = 2'b10;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        base = stb_cnt;
        send(47, 10);
        chk("t6_early", stb_cnt - base, 0);
        pulse1();
        chk("t6_stb", acr_stb, 1);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
